// File: rtl/spi_ram_arbiter.sv
// Shares one single-port RAM between SPI command words and a local host port.
// SPI 00/10 set write/read addresses, 01/11 queue a 1-deep RAM op; round-robin arbitration.
module spi_ram_arbiter #(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE+1:0] rx_data,
    input  logic                 rx_valid,
    output logic [DATA_SIZE-1:0] tx_data,
    output logic                 tx_valid,
    output logic                 spi_drop,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [DATA_SIZE-1:0] host_wdata,
    output logic                 host_gnt,
    output logic [DATA_SIZE-1:0] host_rdata,
    output logic                 host_rvalid,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [DATA_SIZE-1:0] ram_wdata,
    input  logic [DATA_SIZE-1:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

    state_t                 state, state_nx;
    logic [ADDR_SIZE-1:0]   wr_addr, rd_addr;
    logic                   spi_pend, pend_we;
    logic [ADDR_SIZE-1:0]   pend_addr;
    logic [DATA_SIZE-1:0]   pend_wdata;
    logic                   op_spi, op_we;
    logic [ADDR_SIZE-1:0]   op_addr;
    logic [DATA_SIZE-1:0]   op_wdata;
    logic                   last_host;

    logic [1:0]             cmd;
    logic [DATA_SIZE-1:0]   payload;
    logic                   pend_cmd, spi_grant, drop, pick_spi, any_req;

    assign cmd       = rx_data[DATA_SIZE+1:DATA_SIZE];
    assign payload   = rx_data[DATA_SIZE-1:0];
    assign pend_cmd  = rx_valid && cmd[0];
    assign spi_grant = (state == ACCESS) && op_spi;
    // A grant in this cycle frees the slot, so a new 01/11 in the same cycle is kept.
    assign drop      = pend_cmd && spi_pend && !spi_grant;
    assign any_req   = spi_pend || host_req;
    assign pick_spi  = spi_pend && (!host_req || last_host);

    assign ram_addr  = op_addr;
    assign ram_wdata = op_wdata;

    always_comb begin
        state_nx = state;
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        host_gnt = 1'b0;
        case (state)
            IDLE:   if (any_req) state_nx = ACCESS;
            ACCESS: begin
                ram_en   = 1'b1;
                ram_we   = op_we;
                host_gnt = !op_spi;
                state_nx = op_we ? IDLE : RDATA;
            end
            RDATA:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_host <= 1'b1;
            op_spi    <= 1'b0;
            op_we     <= 1'b0;
            op_addr   <= '0;
            op_wdata  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                op_spi    <= pick_spi;
                op_we     <= pick_spi ? pend_we    : host_we;
                op_addr   <= pick_spi ? pend_addr  : host_addr;
                op_wdata  <= pick_spi ? pend_wdata : host_wdata;
                last_host <= !pick_spi;
            end
        end
    end

    // SPI command decode and the single pending-op slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr    <= '0;
            rd_addr    <= '0;
            spi_pend   <= 1'b0;
            pend_we    <= 1'b0;
            pend_addr  <= '0;
            pend_wdata <= '0;
            spi_drop   <= 1'b0;
        end else begin
            spi_drop <= drop;
            if (rx_valid && cmd == 2'b00) wr_addr <= payload[ADDR_SIZE-1:0];
            if (rx_valid && cmd == 2'b10) rd_addr <= payload[ADDR_SIZE-1:0];
            if (pend_cmd && !drop) begin
                spi_pend   <= 1'b1;
                pend_we    <= !cmd[1];
                pend_addr  <= cmd[1] ? rd_addr : wr_addr;
                pend_wdata <= payload;
            end else if (spi_grant) begin
                spi_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            host_rdata  <= '0;
            host_rvalid <= 1'b0;
        end else begin
            host_rvalid <= 1'b0;
            if (state == RDATA && op_spi) begin
                tx_data  <= ram_rdata;
                tx_valid <= 1'b1;
            end else if (rx_valid) begin
                tx_valid <= 1'b0;
            end
            if (state == RDATA && !op_spi) begin
                host_rdata  <= ram_rdata;
                host_rvalid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter with a behavioural registered RAM attached.
module tb_spi_ram_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid, spi_drop;
    logic       host_req, host_we;
    logic [7:0] host_addr, host_wdata, host_rdata;
    logic       host_gnt, host_rvalid;
    logic       ram_en, ram_we;
    logic [7:0] ram_addr, ram_wdata;
    logic [7:0] ram_rdata;
    logic [7:0] mem [256];

    int total = 0;
    int passed = 0;
    int failed = 0;

    spi_ram_arbiter #(.ADDR_SIZE(8), .DATA_SIZE(8)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .spi_drop(spi_drop),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Registered single-port RAM: read data valid the cycle after ram_en
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spi(input logic [9:0] w);
        rx_data  = w;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rx_data = '0; rx_valid = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        tick(); tick();
        chk("rst_ram_en", ram_en, 0);
        chk("rst_host_gnt", host_gnt, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_rvalid", host_rvalid, 0);
        rst = 1'b0;
        tick();
        chk("idle_ram_en", ram_en, 0);

        // Preload RAM[0x10]=0x3C via a host write
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'h3C;
        tick();
        chk("hw_gnt", host_gnt, 1);
        chk("hw_we", ram_we, 1);
        host_req = 1'b0;
        tick();
        chk("hw_gnt_off", host_gnt, 0);

        // SPI write 0xA5 to 0x05
        spi(10'h005); spi(10'h1A5);
        tick();
        chk("t1_en", ram_en, 1);
        chk("t1_we", ram_we, 1);
        chk("t1_addr", ram_addr, 8'h05);
        chk("t1_wdata", ram_wdata, 8'hA5);
        chk("t1_nogrant", host_gnt, 0);
        tick();
        chk("t1_en_off", ram_en, 0);
        chk("t1_addr_hold", ram_addr, 8'h05);

        // SPI read of 0x05
        spi(10'h205); spi(10'h300);
        tick();
        chk("t2_en", ram_en, 1);
        chk("t2_we", ram_we, 0);
        chk("t2_addr", ram_addr, 8'h05);
        tick();
        chk("t2_txv_early", tx_valid, 0);
        tick();
        chk("t2_txv", tx_valid, 1);
        chk("t2_txd", tx_data, 8'hA5);
        tick(); tick();
        chk("t2_txv_held", tx_valid, 1);
        spi(10'h005);
        chk("t2_txv_clr", tx_valid, 0);

        // Host read of 0x10
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        tick();
        chk("t3_gnt", host_gnt, 1);
        chk("t3_addr", ram_addr, 8'h10);
        host_req = 1'b0;
        tick();
        chk("t3_rv_early", host_rvalid, 0);
        tick();
        chk("t3_rv", host_rvalid, 1);
        chk("t3_rd", host_rdata, 8'h3C);
        tick();
        chk("t3_rv_pulse", host_rvalid, 0);

        // Round robin after reset: SPI, host, SPI, host
        rst = 1'b1; tick(); rst = 1'b0; tick();
        spi(10'h020); spi(10'h111);
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h30; host_wdata = 8'h77;
        tick();
        chk("t4_s1_gnt", host_gnt, 0);
        chk("t4_s1_addr", ram_addr, 8'h20);
        chk("t4_s1_wdata", ram_wdata, 8'h11);
        tick();
        chk("t4_gap", ram_en, 0);
        tick();
        chk("t4_h1_gnt", host_gnt, 1);
        chk("t4_h1_addr", ram_addr, 8'h30);
        spi(10'h122);
        tick();
        chk("t4_s2_gnt", host_gnt, 0);
        chk("t4_s2_en", ram_en, 1);
        chk("t4_s2_wdata", ram_wdata, 8'h22);
        tick();
        tick();
        chk("t4_h2_gnt", host_gnt, 1);
        host_req = 1'b0;
        tick();

        // Second SPI write dropped while the first waits behind a host read
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        tick();
        chk("t5_hgnt", host_gnt, 1);
        host_req = 1'b0;
        spi(10'h040);
        spi(10'h1AA);
        chk("t5_no_drop", spi_drop, 0);
        spi(10'h1BB);
        chk("t5_drop", spi_drop, 1);
        chk("t5_wdata", ram_wdata, 8'hAA);
        chk("t5_addr", ram_addr, 8'h40);
        chk("t5_we", ram_we, 1);
        tick();
        chk("t5_drop_pulse", spi_drop, 0);
        chk("t5_en_off", ram_en, 0);
        tick();
        chk("t5_no_second", ram_en, 0);
        chk("t5_mem", mem[8'h40], 8'hAA);

        // Reset during the ACCESS cycle of a host read
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        tick();
        chk("t6_gnt", host_gnt, 1);
        #1 rst = 1'b1;
        #1;
        chk("t6_async_en", ram_en, 0);
        chk("t6_async_gnt", host_gnt, 0);
        chk("t6_async_addr", ram_addr, 0);
        host_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("t6_rv0", host_rvalid, 0);
        tick();
        chk("t6_rv1", host_rvalid, 0);
        chk("t6_txv", tx_valid, 0);
        chk("t6_en", ram_en, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
